// File: rtl/led_pattern_serializer.sv
// rtl/led_pattern_serializer.sv - parallel-in serial-out transmitter for the LED chain shift register
module led_pattern_serializer #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 25
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_dir,
    input  logic              stop,
    output logic              ser_data,
    output logic              ser_clk,
    output logic              ser_latch,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLK_LO,
        CLK_HI,
        LATCH
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shadow;
    logic              dir_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  next_idx;
    logic              next_bit;

    assign load_ready = (state == IDLE) && !stop;

    // Bits always come from the captured copy, so load_data may change freely while busy.
    assign next_idx = bit_cnt + BIT_W'(1);
    assign next_bit = dir_q ? shadow[next_idx] : shadow[BIT_LAST - next_idx];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            dir_q     <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (load_valid && load_ready) begin
                    shadow   <= load_data;
                    dir_q    <= load_dir;
                    state    <= CLK_LO;
                    busy     <= 1'b1;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    ser_data <= load_dir ? load_data[0] : load_data[DATA_W-1];
                end
            end else if (!stop) begin
                // stop freezes everything in place, which stretches rather than cuts a phase.
                if (div_cnt != DIV_LAST) begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end else begin
                    div_cnt <= '0;
                    case (state)
                        CLK_LO: begin
                            ser_clk <= 1'b1;
                            state   <= CLK_HI;
                        end
                        CLK_HI: begin
                            ser_clk <= 1'b0;
                            if (bit_cnt != BIT_LAST) begin
                                bit_cnt  <= next_idx;
                                ser_data <= next_bit;
                                state    <= CLK_LO;
                            end else begin
                                ser_latch <= 1'b1;
                                state     <= LATCH;
                            end
                        end
                        LATCH: begin
                            ser_latch <= 1'b0;
                            ser_data  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
